// File: rtl/control_multicycle.sv
// Multi-cycle control FSM: accepts one instruction per valid/ready handshake and
// sequences decode, ALU, memory and writeback strobes for R, I-ALU, LW, SW and BEQ/BNE.
//
// state  | meaning
// FETCH  | idle, instr_ready=1, waiting for an instruction
// DECODE | classify the latched instruction
// EXEC   | R/I ALU operation
// WB     | register write and PC+4 update
// ADDR   | load/store address calculation
// MEM    | data memory access, bounded by the timeout counter
// BRANCH | compare via SUB, select PC source from alu_zero
// TRAP   | illegal_instr pulse
module control_multicycle #(
    parameter int XLEN         = 32,
    parameter int ALU_CTRL_W   = 4,
    parameter int ENABLE_ITYPE = 1,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [XLEN-1:0]       instruction_word,
    input  logic                  alu_zero,
    input  logic                  mem_ready,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_src_imm,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  pc_write,
    output logic                  pc_sel_branch,
    output logic                  illegal_instr,
    output logic                  bus_error
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_ADDR, S_MEM, S_BRANCH, S_TRAP
    } state_t;

    state_t          state, state_nxt;
    logic [6:0]      ir_opcode;
    logic [2:0]      ir_funct3;
    logic [6:0]      ir_funct7;
    logic [TW-1:0]   tmo_cnt;
    logic [3:0]      alu_hold, alu_op;
    logic            is_r, is_i, is_load, is_store, is_branch;
    logic [3:0]      exec_op;

    // Only the decode fields of the instruction register are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            ir_opcode <= '0;
            ir_funct3 <= '0;
            ir_funct7 <= '0;
            tmo_cnt   <= '0;
            alu_hold  <= '0;
        end else begin
            state    <= state_nxt;
            alu_hold <= alu_op;
            if (state == S_FETCH && instr_valid) begin
                ir_opcode <= instruction_word[6:0];
                ir_funct3 <= instruction_word[14:12];
                ir_funct7 <= instruction_word[31:25];
            end
            if (state == S_ADDR)
                tmo_cnt <= TW'(MEM_TIMEOUT - 1);
            else if (state == S_MEM && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    always_comb begin
        is_r      = 1'b0;
        is_i      = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        case (ir_opcode)
            OP_R: is_r = (ir_funct7 == 7'b0000000) ||
                         (ir_funct7 == 7'b0100000 && (ir_funct3 == 3'b000 || ir_funct3 == 3'b101));
            OP_I: begin
                if (ENABLE_ITYPE != 0) begin
                    case (ir_funct3)
                        3'b001:  is_i = (ir_funct7 == 7'b0000000);
                        3'b101:  is_i = (ir_funct7 == 7'b0000000) || (ir_funct7 == 7'b0100000);
                        default: is_i = 1'b1;
                    endcase
                end
            end
            OP_LOAD:   is_load   = (ir_funct3 == 3'b010);
            OP_STORE:  is_store  = (ir_funct3 == 3'b010);
            OP_BRANCH: is_branch = (ir_funct3 == 3'b000) || (ir_funct3 == 3'b001);
            default: ;
        endcase
        // f7b5 (IR[30]) only qualifies I-type shifts; other I-ops ignore it.
        if (is_i && ir_funct3 != 3'b101)
            exec_op = {1'b0, ir_funct3};
        else
            exec_op = {ir_funct7[5], ir_funct3};
    end

    always_comb begin
        state_nxt     = state;
        alu_op        = alu_hold;
        instr_ready   = 1'b0;
        alu_src_imm   = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        pc_write      = 1'b0;
        pc_sel_branch = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        case (state)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_r || is_i)            state_nxt = S_EXEC;
                else if (is_load || is_store) state_nxt = S_ADDR;
                else if (is_branch)          state_nxt = S_BRANCH;
                else                         state_nxt = S_TRAP;
            end
            S_EXEC: begin
                alu_op      = exec_op;
                alu_src_imm = is_i;
                state_nxt   = S_WB;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = is_load;
                state_nxt  = S_FETCH;
            end
            S_ADDR: begin
                alu_op      = ALU_ADD;
                alu_src_imm = 1'b1;
                state_nxt   = S_MEM;
            end
            S_MEM: begin
                alu_op      = ALU_ADD;
                alu_src_imm = 1'b1;
                mem_read    = is_load;
                mem_write   = is_store;
                // A late mem_ready on the terminal-count cycle still completes the access.
                if (mem_ready) begin
                    if (is_load) begin
                        state_nxt = S_WB;
                    end else begin
                        pc_write  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (tmo_cnt == '0) begin
                    bus_error = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_op        = ALU_SUB;
                pc_write      = 1'b1;
                pc_sel_branch = (ir_funct3 == 3'b000) ? alu_zero : ~alu_zero;
                state_nxt     = S_FETCH;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_nxt     = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign alu_ctrl = ALU_CTRL_W'(alu_op);

endmodule

// File: tb/tb_control_multicycle.sv
// Bench for control_multicycle: directed cases with literal expectations plus
// random instructions, checked every cycle against a per-transaction output trace model.
module tb_control_multicycle;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst, instr_valid, instr_valid1, alu_zero, mem_ready;
    logic [31:0] instruction_word;

    logic        instr_ready, alu_src_imm, reg_write, mem_to_reg, mem_read, mem_write;
    logic        pc_write, pc_sel_branch, illegal_instr, bus_error;
    logic [3:0]  alu_ctrl;

    logic        instr_ready1, alu_src_imm1, reg_write1, mem_to_reg1, mem_read1, mem_write1;
    logic        pc_write1, pc_sel_branch1, illegal_instr1, bus_error1;
    logic [5:0]  alu_ctrl1;

    control_multicycle #(.XLEN(32), .ALU_CTRL_W(4), .ENABLE_ITYPE(1), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction_word(instruction_word), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
        .illegal_instr(illegal_instr), .bus_error(bus_error));

    control_multicycle #(.XLEN(32), .ALU_CTRL_W(6), .ENABLE_ITYPE(0), .MEM_TIMEOUT(TMO)) dut1 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid1), .instr_ready(instr_ready1),
        .instruction_word(instruction_word), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl1), .alu_src_imm(alu_src_imm1), .reg_write(reg_write1),
        .mem_to_reg(mem_to_reg1), .mem_read(mem_read1), .mem_write(mem_write1),
        .pc_write(pc_write1), .pc_sel_branch(pc_sel_branch1),
        .illegal_instr(illegal_instr1), .bus_error(bus_error1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic [3:0] alu;
        logic       imm, rw, m2r, mrd, mwr, pcw, pcsel, ill, berr;
    } outs_t;

    typedef struct packed {
        logic       alu_valid;
        logic [3:0] alu;
        logic       imm, rw, m2r, mrd, mwr, pcw;
        logic [1:0] br_kind;  // 0 none, 1 beq, 2 bne
        logic       ill, berr;
    } exp_t;

    exp_t       q[$];
    logic [3:0] alu_last;
    bit         chk_en = 0;
    int         total = 0, bad = 0;
    outs_t      rec[0:63];

    function automatic outs_t sample0();
        return {instr_ready, alu_ctrl, alu_src_imm, reg_write, mem_to_reg, mem_read,
                mem_write, pc_write, pc_sel_branch, illegal_instr, bus_error};
    endfunction

    // kind: 0 illegal, 1 R, 2 I, 3 load, 4 store, 5 beq, 6 bne
    function automatic int classify(input logic [31:0] w, input bit itype_en, output logic [3:0] op);
        logic [6:0] opc = w[6:0];
        logic [6:0] f7  = w[31:25];
        logic [2:0] f3  = w[14:12];
        op = 4'b0000;
        case (opc)
            7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                op = {w[30], f3}; return 1;
            end
            7'b0010011: if (itype_en) begin
                if (f3 == 3'd1 && f7 != 7'h00) return 0;
                if (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) return 0;
                op = (f3 == 3'd5) ? {w[30], 3'b101} : {1'b0, f3};
                return 2;
            end
            7'b0000011: if (f3 == 3'd2) return 3;
            7'b0100011: if (f3 == 3'd2) return 4;
            7'b1100011: if (f3 == 3'd0) return 5; else if (f3 == 3'd1) return 6;
            default: ;
        endcase
        return 0;
    endfunction

    // Queue the expected output trace, one entry per cycle after the transfer edge.
    function automatic int build(input logic [31:0] w, input int d, output int kind);
        exp_t e;
        logic [3:0] op;
        int n, len;
        kind = classify(w, 1'b1, op);
        e = '0; q.push_back(e); len = 1;
        case (kind)
            0: begin e = '0; e.ill = 1; q.push_back(e); len++; end
            1, 2: begin
                e = '0; e.alu_valid = 1; e.alu = op; e.imm = (kind == 2); q.push_back(e);
                e = '0; e.rw = 1; e.pcw = 1; q.push_back(e);
                len += 2;
            end
            3, 4: begin
                e = '0; e.alu_valid = 1; e.imm = 1; q.push_back(e); len++;
                n = (d <= TMO) ? d : TMO;
                for (int j = 1; j <= n; j++) begin
                    e = '0; e.alu_valid = 1; e.imm = 1;
                    e.mrd = (kind == 3); e.mwr = (kind == 4);
                    if (j == n) begin
                        if (d > TMO) e.berr = 1;
                        else if (kind == 4) e.pcw = 1;
                    end
                    q.push_back(e); len++;
                end
                if (kind == 3 && d <= TMO) begin
                    e = '0; e.rw = 1; e.pcw = 1; e.m2r = 1; q.push_back(e); len++;
                end
            end
            default: begin
                e = '0; e.alu_valid = 1; e.alu = 4'b1000; e.pcw = 1;
                e.br_kind = (kind == 5) ? 2'd1 : 2'd2; q.push_back(e); len++;
            end
        endcase
        return len;
    endfunction

    always @(negedge clk) begin
        exp_t  e;
        outs_t ex, act;
        bit    idle;
        if (chk_en) begin
            idle = (q.size() == 0);
            e = idle ? exp_t'('0) : q.pop_front();
            if (e.alu_valid) alu_last = e.alu;
            ex.ready = idle;
            ex.alu   = alu_last;
            ex.imm   = e.imm; ex.rw = e.rw; ex.m2r = e.m2r; ex.mrd = e.mrd; ex.mwr = e.mwr;
            ex.pcw   = e.pcw; ex.ill = e.ill; ex.berr = e.berr;
            ex.pcsel = (e.br_kind == 2'd1) ? alu_zero : (e.br_kind == 2'd2) ? ~alu_zero : 1'b0;
            act = sample0();
            total++;
            if (act !== ex) begin
                bad++;
                $display("FAIL cycle_trace t=%0t got=%b want=%b (rdy,alu,imm,rw,m2r,mrd,mwr,pcw,psel,ill,berr)",
                         $time, act, ex);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // z: -1 random alu_zero, else forced value. Records outputs of cycles 0..len.
    task automatic send(input logic [31:0] w, input int d, input int gap, input int z);
        int len, kind, n;
        repeat (gap) begin
            instr_valid = 0; instruction_word = $urandom; mem_ready = 1'($urandom);
            alu_zero = 1'($urandom);
            @(posedge clk); #1;
        end
        instr_valid = 1; instruction_word = w; mem_ready = 1'($urandom); alu_zero = 1'($urandom);
        @(posedge clk); #1;
        len = build(w, d, kind);
        n = (d <= TMO) ? d : TMO;
        instr_valid = 0;
        for (int i = 0; i < len; i++) begin
            instruction_word = $urandom;
            alu_zero = (z < 0) ? 1'($urandom) : 1'(z);
            if ((kind == 3 || kind == 4) && i >= 2 && i < 2 + n)
                mem_ready = (i == d + 1) && (d <= TMO);
            else
                mem_ready = 1'($urandom);
            #3 rec[i] = sample0();
            @(posedge clk); #1;
        end
        #3 rec[len] = sample0();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b0110011, 7'b1111111};
        logic [6:0] opc = opcs[$urandom_range(0, 6)];
        logic [2:0] f3  = 3'($urandom);
        logic [6:0] f7;
        int sel = $urandom_range(0, 3);
        if (opc == 7'b1111111) opc = 7'($urandom);
        if ((opc == 7'b0000011 || opc == 7'b0100011) && $urandom_range(0, 3) != 0) f3 = 3'd2;
        f7 = (sel == 0) ? 7'h20 : (sel == 3) ? 7'($urandom) : 7'h00;
        return {f7, 10'($urandom), f3, 5'($urandom), opc};
    endfunction

    initial begin
        logic [31:0] w;
        rst = 1; instr_valid = 0; instr_valid1 = 0; alu_zero = 0; mem_ready = 0;
        instruction_word = '0; alu_last = '0;
        repeat (3) @(posedge clk);
        #1;
        lit("reset_outputs", 32'(sample0()), 32'(outs_t'(14'b1_0000_000000000)));
        lit("reset_dut1_ready_alu", {instr_ready1, alu_ctrl1}, {1'b1, 6'b0});
        rst = 0; chk_en = 1;

        send(32'b0000000_00100_10101_000_00101_0110011, 0, 0, -1);
        lit("add_exec_alu", rec[1].alu, 4'b0000);
        lit("add_wb_strobes", {rec[2].rw, rec[2].pcw, rec[2].ready}, 3'b110);
        lit("add_ready_T4", rec[3].ready, 1'b1);

        send(32'b0100000_00101_10101_000_00110_0110011, 0, 1, -1);
        lit("sub_alu", rec[1].alu, 4'b1000);
        send(32'b0000000_00101_10101_001_00110_0110011, 0, 0, -1);
        lit("sll_alu", rec[1].alu, 4'b0001);
        send(32'b0100000_00101_10101_001_00110_0110011, 0, 0, -1);
        lit("illegal_T2", {rec[1].ill, rec[0].ill, rec[2].ready}, 3'b101);

        send(32'b000000000100_00010_010_00011_0000011, 3, 0, -1);
        lit("lw_mem_read", {rec[2].mrd, rec[3].mrd, rec[4].mrd, rec[5].mrd}, 4'b1110);
        lit("lw_wb", {rec[5].rw, rec[5].m2r, rec[5].pcw}, 3'b111);
        send(32'b0000000_00011_00010_010_00100_0100011, 2, 0, -1);
        lit("sw_done", {rec[3].mwr, rec[3].pcw, rec[3].rw, rec[4].ready}, 4'b1101);

        send(32'b0000000_00010_00001_000_01000_1100011, 0, 0, 1);
        lit("beq_taken", {rec[1].pcw, rec[1].pcsel, rec[1].alu}, {2'b11, 4'b1000});
        send(32'b0000000_00010_00001_001_01000_1100011, 0, 0, 1);
        lit("bne_not_taken", {rec[1].pcw, rec[1].pcsel}, 2'b10);

        send(32'b000000000100_00010_010_00011_0000011, 100, 0, -1);
        lit("timeout_berr", {rec[16].berr, rec[17].berr, rec[17].rw, rec[17].pcw}, 4'b0100);
        lit("timeout_fetch", {rec[18].ready, rec[18].rw}, 2'b10);

        // Reset in the third MEM cycle of a load.
        w = 32'b000000000100_00010_010_00011_0000011;
        instr_valid = 1; instruction_word = w; mem_ready = 0;
        @(posedge clk); #1;
        begin
            int k, len;
            len = build(w, 100, k);
        end
        instr_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        #3 lit("mid_mem_read_before_rst", mem_read, 1'b1);
        @(posedge clk); #1;
        q.delete(); alu_last = '0; rst = 0;
        #3 lit("after_rst_idle", 32'(sample0()), 32'(outs_t'(14'b1_0000_000000000)));
        @(posedge clk); #1;

        // ADDI on the variant without I-type support.
        instr_valid1 = 1; instruction_word = 32'b000000000101_00001_000_00010_0010011;
        @(posedge clk); #1;
        instr_valid1 = 0;
        #3 lit("itype_off_decode", {illegal_instr1, instr_ready1}, 2'b00);
        @(posedge clk); #4;
        lit("itype_off_illegal", {illegal_instr1, reg_write1, alu_ctrl1}, {2'b10, 6'b0});
        @(posedge clk); #4;
        lit("itype_off_ready", instr_ready1, 1'b1);
        @(posedge clk); #1;

        for (int t = 0; t < 300; t++)
            send(rand_instr(), $urandom_range(1, 20), $urandom_range(0, 2), -1);

        @(posedge clk); #1;
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
